output_sr_unq1: RTL and testbench
=================================

OUTPUT_SR_UNQ1 -- requirements
Module: output_sr_unq1

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 data_in  input  32  write data; lane 0 = [15:0], lane 1 = [31:16].
REQ-005 wen_w1  input  1  write one word (lane 0 only).
REQ-006 wen_w2  input  1  write two words (lane 0, then lane 1).
REQ-007 room_w1  output  1  space for at least 1 word (count <= 2).
REQ-008 room_w2  output  1  space for at least 2 words (count <= 1).
REQ-009 ren  input  1  downstream pop of head word.
REQ-010 valid  output  1  head word present (count != 0).
REQ-011 data_out  output  16  head word, registered.
REQ-012 count  output  2  occupied entries, 0..3.

Function
REQ-013 Storage SHALL be a 3-entry x 16-bit shift register; entry 0 is the head, driven on data_out.
REQ-014 room_w1, room_w2, valid SHALL be combinational from the registered count only; no same-cycle pop credit.
REQ-015 A wen_w1 with room_w1=1 SHALL append data_in[15:0]; count +1.
REQ-016 A wen_w2 with room_w2=1 SHALL append data_in[15:0], then data_in[31:16]; count +2.
REQ-017 A wen_w2 with room_w2=0 SHALL be dropped whole; no partial write of lane 0.
REQ-018 A wen_w1 with room_w1=0 SHALL be dropped; storage and count unchanged.
REQ-019 If wen_w1 and wen_w2 are both high, wen_w2 SHALL win and wen_w1 SHALL be ignored.
REQ-020 A ren with valid=1 SHALL shift entries toward the head; count -1.
REQ-021 A ren with valid=0 SHALL be ignored.
REQ-022 A same-cycle accepted pop and accepted write SHALL both take effect: next count = count + written - 1. Written words land behind the surviving entries.
REQ-023 Write-to-output latency SHALL be 1 cycle: a word written into an empty block at edge N appears on data_out with valid=1 after edge N.
REQ-024 Words SHALL leave in write order, one per accepted pop; no reordering or duplication.
REQ-025 Unoccupied entries and data_out with valid=0 SHALL hold their last value; consumers SHALL qualify data_out with valid.

Reset
REQ-026 Reset asserted SHALL immediately force count=0, valid=0, room_w1=1, room_w2=1, data_out=16'h0000, and all entries to 0.
REQ-027 Reset mid-transfer SHALL discard all buffered words.
REQ-028 Writes and pops in the first cycle after reset deassertion SHALL be honoured normally.

Configuration
REQ-029 Macro OUTPUT_SR_OVF_EN SHALL control overflow/underflow error reporting.
REQ-030 With OUTPUT_SR_OVF_EN defined, the block SHALL add output port ovf (1 bit). ovf is a sticky flag, set the cycle after any dropped write (REQ-017/018) or ignored ren (REQ-021). Only reset clears it; reset value 0.
REQ-031 Without OUTPUT_SR_OVF_EN, the ovf port and its logic SHALL be absent; drops stay silent. All other behaviour is identical.

Verification
REQ-032 Reset, then wen_w2 with data_in=32'hBBBB_AAAA, then ren held high -> data_out AAAA then BBBB on consecutive cycles; count 2,1,0; valid falls after BBBB.
REQ-033 From empty: wen_w2 32'h2222_1111, then wen_w1 32'h0000_3333 -> count=3, room_w1=0. A further wen_w1 32'h0000_4444 is dropped; the pop order is 1111, 2222, 3333. With OUTPUT_SR_OVF_EN, ovf=1.
REQ-034 count=2 (room_w2=0), wen_w2 32'h6666_5555 with ren=1 in the same cycle -> write dropped (no pop credit), head popped, count=1.
REQ-035 count=1, same-cycle wen_w1 32'h0000_7777 and ren=1 -> count stays 1, next data_out=7777.
REQ-036 wen_w1 and wen_w2 both high, data_in=32'h9999_8888, empty -> count=2, pop order 8888, 9999.
REQ-037 count=3; reset asserted asynchronously mid-cycle -> outputs reach reset values before the next clock edge; ren on empty after release -> count stays 0, and ovf=1 only if OUTPUT_SR_OVF_EN is defined.

Source files
------------

// File: rtl/output_sr_unq1.sv
// output_sr_unq1 -- 3-entry x 16-bit output shift register with 1- and
// 2-word writes and a single-word pop from the head.
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     asynchronous, active-low reset (0 = in reset)
//   data_in   write data; lane 0 = [15:0], lane 1 = [31:16]
//   wen_w1    write one word (lane 0)
//   wen_w2    write two words (lane 0 then lane 1); wins over wen_w1
//   room_w1   space for at least one word (count <= 2)
//   room_w2   space for at least two words (count <= 1)
//   ren       pop the head word
//   valid     head word present (count != 0)
//   data_out  head word (entry 0, registered)
//   count     occupied entries, 0..3
//   ovf       sticky drop/underflow flag (only with OUTPUT_SR_OVF_EN)
//
// Build option: define OUTPUT_SR_OVF_EN to add the ovf port. Without it,
// dropped writes and ignored pops are silent.

module output_sr_unq1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        wen_w1,
  input  logic        wen_w2,
  output logic        room_w1,
  output logic        room_w2,
  input  logic        ren,
  output logic        valid,
  output logic [15:0] data_out,
  output logic [1:0]  count
`ifdef OUTPUT_SR_OVF_EN
  ,
  output logic        ovf
`endif
);

  logic [15:0] entry_q [3];
  logic [15:0] entry_d [3];
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [1:0]  base;
  logic [1:0]  wr_num;
  logic        pop_acc;
  logic        w1_acc;
  logic        w2_acc;

  // Flags come from the registered count only; a pop in the same cycle
  // does not create room for a write.
  assign room_w1  = (count_q <= 2'd2);
  assign room_w2  = (count_q <= 2'd1);
  assign valid    = (count_q != 2'd0);
  assign count    = count_q;
  assign data_out = entry_q[0];

  assign w2_acc  = wen_w2 && room_w2;
  assign w1_acc  = wen_w1 && !wen_w2 && room_w1;
  assign pop_acc = ren && valid;
  assign wr_num  = w2_acc ? 2'd2 : (w1_acc ? 2'd1 : 2'd0);
  // First free slot after the (optional) pop has shifted survivors forward.
  assign base    = count_q - {1'b0, pop_acc};
  assign count_d = count_q + wr_num - {1'b0, pop_acc};

  always_comb begin
    for (int i = 0; i < 3; i++) entry_d[i] = entry_q[i];
    // Only occupied entries shift, so data_out holds its last word once
    // the register drains.
    if (pop_acc) begin
      if (count_q >= 2'd2) entry_d[0] = entry_q[1];
      if (count_q == 2'd3) entry_d[1] = entry_q[2];
    end
    for (int i = 0; i < 3; i++) begin
      if ((w1_acc || w2_acc) && base == 2'(i)) entry_d[i] = data_in[15:0];
      if (w2_acc && (base + 2'd1) == 2'(i))    entry_d[i] = data_in[31:16];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      for (int i = 0; i < 3; i++) entry_q[i] <= 16'h0000;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < 3; i++) entry_q[i] <= entry_d[i];
    end
  end

`ifdef OUTPUT_SR_OVF_EN
  logic drop;

  // A wen_w1 alongside a dropped wen_w2 is ignored, and that counts as
  // part of the same drop event.
  assign drop = (wen_w2 && !room_w2) ||
                (wen_w1 && !wen_w2 && !room_w1) ||
                (ren && !valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_output_sr_unq1.sv
// Directed testbench for output_sr_unq1. Inputs change 1 ns after each
// rising edge; outputs are checked at the same point.

module tb_output_sr_unq1;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        wen_w1;
  logic        wen_w2;
  logic        room_w1;
  logic        room_w2;
  logic        ren;
  logic        valid;
  logic [15:0] data_out;
  logic [1:0]  count;
`ifdef OUTPUT_SR_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  output_sr_unq1 dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .wen_w1   (wen_w1),
    .wen_w2   (wen_w2),
    .room_w1  (room_w1),
    .room_w2  (room_w2),
    .ren      (ren),
    .valid    (valid),
    .data_out (data_out),
    .count    (count)
`ifdef OUTPUT_SR_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w1, input logic w2, input logic r, input logic [31:0] d);
    wen_w1  = w1;
    wen_w2  = w2;
    ren     = r;
    data_in = d;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] c, input logic [15:0] d);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_valid"}, 32'(valid), 32'(c != 2'd0));
    if (c != 2'd0 || d != 16'h0) chk({tag, "_data"}, 32'(data_out), 32'(d));
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_room1", 32'(room_w1), 32'd1);
    chk("rst_room2", 32'(room_w2), 32'd1);
    chk("rst_data",  32'(data_out), 32'h0);
`ifdef OUTPUT_SR_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    step();
    step();
    reset = 1'b1;

    // Two-word write then drain
    drive(1'b0, 1'b1, 1'b0, 32'hBBBB_AAAA);
    step();
    chk_state("w2a", 2'd2, 16'hAAAA);
    chk("w2a_room1", 32'(room_w1), 32'd1);
    chk("w2a_room2", 32'(room_w2), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk_state("pop1", 2'd1, 16'hBBBB);
    step();
    chk("pop2_count", 32'(count), 32'd0);
    chk("pop2_valid", 32'(valid), 32'd0);
    chk("pop2_hold",  32'(data_out), 32'hBBBB);
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Fill to 3, dropped wen_w1, drain in order
    drive(1'b0, 1'b1, 1'b0, 32'h2222_1111);
    step();
    chk_state("fill2", 2'd2, 16'h1111);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3333);
    step();
    chk_state("fill3", 2'd3, 16'h1111);
    chk("fill3_room1", 32'(room_w1), 32'd0);
    chk("fill3_room2", 32'(room_w2), 32'd0);
`ifdef OUTPUT_SR_OVF_EN
    chk("fill3_ovf", 32'(ovf), 32'd0);
`endif
    drive(1'b1, 1'b0, 1'b0, 32'h0000_4444);
    step();
    chk_state("drop1", 2'd3, 16'h1111);
`ifdef OUTPUT_SR_OVF_EN
    chk("drop1_ovf", 32'(ovf), 32'd1);
`endif
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk_state("ord2", 2'd2, 16'h2222);
    step();
    chk_state("ord3", 2'd1, 16'h3333);
    step();
    chk("ord_empty", 32'(count), 32'd0);
    chk("ord_hold", 32'(data_out), 32'h3333);

    // count=2: wen_w2 with pop -> write dropped, pop taken
    drive(1'b1, 1'b0, 1'b0, 32'h0000_A001);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_A002);
    step();
    chk_state("c2", 2'd2, 16'hA001);
    drive(1'b0, 1'b1, 1'b1, 32'h6666_5555);
    step();
    chk_state("nocredit", 2'd1, 16'hA002);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("nocredit_empty", 32'(count), 32'd0);

    // count=1: wen_w1 with pop
    drive(1'b1, 1'b0, 1'b0, 32'h0000_B001);
    step();
    chk_state("c1", 2'd1, 16'hB001);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_7777);
    step();
    chk_state("w1pop", 2'd1, 16'h7777);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("w1pop_empty", 32'(count), 32'd0);

    // count=1: wen_w2 with pop -> new words land behind survivor slot
    drive(1'b1, 1'b0, 1'b0, 32'h0000_C001);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'hC003_C002);
    step();
    chk_state("w2pop", 2'd2, 16'hC002);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk_state("w2pop_b", 2'd1, 16'hC003);
    step();
    chk("w2pop_empty", 32'(count), 32'd0);

    // Both write enables: wen_w2 wins
    drive(1'b1, 1'b1, 1'b0, 32'h9999_8888);
    step();
    chk_state("both", 2'd2, 16'h8888);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk_state("both_b", 2'd1, 16'h9999);
    step();
    chk("both_empty", 32'(count), 32'd0);

    // Fill to 3 then asynchronous reset mid-cycle
    drive(1'b0, 1'b1, 1'b0, 32'hD002_D001);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_D003);
    step();
    chk_state("pre_rst", 2'd3, 16'hD001);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_room1", 32'(room_w1), 32'd1);
    chk("arst_room2", 32'(room_w2), 32'd1);
    chk("arst_data",  32'(data_out), 32'h0);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("under_count", 32'(count), 32'd0);
    chk("under_valid", 32'(valid), 32'd0);
`ifdef OUTPUT_SR_OVF_EN
    chk("under_ovf", 32'(ovf), 32'd1);
`endif

    // Write honoured in first cycle after reset release
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_E001);
    step();
    chk_state("post_rst", 2'd1, 16'hE001);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
